// File: rtl/fighter_action_sched.sv
// Per-frame action scheduler for one fighter: arbitrates walk/crouch/jump/punch/hitstun
// from keyboard state and emits registered motion deltas and status.
module fighter_action_sched #(
    parameter logic [7:0] KEY_LEFT    = 8'h0D,
    parameter logic [7:0] KEY_RIGHT   = 8'h0F,
    parameter logic [7:0] KEY_DOWN    = 8'h0E,
    parameter logic [7:0] KEY_UP      = 8'h0C,
    parameter logic [7:0] KEY_ATK     = 8'h10,
    parameter int         MIN_DIST    = 105,
    parameter int         BOUND_X_MAX = 635,
    parameter int         SPRITE_W    = 125,
    parameter int         WALK_SPD    = 2,
    parameter int         JUMP_V0     = 12,
    parameter int         KNOCK       = 3,
    parameter int         HITSTUN_LEN = 12
) (
    input  logic       frame_clk,
    input  logic       Reset,
    input  logic [7:0] keycode_0,
    input  logic [7:0] keycode_1,
    input  logic [7:0] keycode_2,
    input  logic [7:0] keycode_3,
    input  logic [9:0] XDist,
    input  logic [9:0] PosX,
    input  logic       Hit,
    output logic [9:0] X_Motion,
    output logic [9:0] Y_Motion,
    output logic [2:0] State,
    output logic       AttackActive,
    output logic       Airborne
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_WALK    = 3'd1,
        S_CROUCH  = 3'd2,
        S_JUMP    = 3'd3,
        S_ATTACK  = 3'd4,
        S_HITSTUN = 3'd5
    } state_t;

    localparam logic [9:0]  MIN_DIST_W  = 10'(MIN_DIST);
    localparam logic [10:0] BOUND_W     = 11'(BOUND_X_MAX);
    localparam logic [10:0] SPRITE_W_W  = 11'(SPRITE_W);
    localparam logic [9:0]  WALK_POS    = 10'(WALK_SPD);
    localparam logic [9:0]  WALK_NEG    = 10'(-WALK_SPD);
    localparam logic [9:0]  JUMP_V0_W   = 10'(JUMP_V0);
    localparam logic [9:0]  KNOCK_W     = 10'(KNOCK);
    localparam logic [4:0]  JUMP_LAST   = 5'(2 * JUMP_V0);
    localparam logic [4:0]  ATK_LAST    = 5'd12;
    localparam logic [4:0]  ATK_ON_LO   = 5'd4;
    localparam logic [4:0]  ATK_ON_HI   = 5'd6;
    localparam logic [4:0]  HS_LAST     = 5'(HITSTUN_LEN - 1);

    state_t     state_q, state_d;
    logic [4:0] cnt_q, cnt_d;
    logic [9:0] x_q, x_d, y_q, y_d;
    logic [9:0] jump_x_q, jump_x_d;
    logic       aa_q, aa_d;
    logic       air_q, air_d;
    logic       pend_q, pend_d;
    logic       atk_prev_q;

    logic left, right, down, up, atk, atk_rise;
    logic right_fits, restart, entry;
    logic [9:0] walk_x;

    function automatic logic key_held(input logic [7:0] k, input logic [7:0] a,
                                      input logic [7:0] b, input logic [7:0] c,
                                      input logic [7:0] d);
        return (a == k) || (b == k) || (c == k) || (d == k);
    endfunction

    always_comb begin
        left     = key_held(KEY_LEFT,  keycode_0, keycode_1, keycode_2, keycode_3);
        right    = key_held(KEY_RIGHT, keycode_0, keycode_1, keycode_2, keycode_3);
        down     = key_held(KEY_DOWN,  keycode_0, keycode_1, keycode_2, keycode_3);
        up       = key_held(KEY_UP,    keycode_0, keycode_1, keycode_2, keycode_3);
        atk      = key_held(KEY_ATK,   keycode_0, keycode_1, keycode_2, keycode_3);
        atk_rise = atk && !atk_prev_q;
        // 11-bit sum so PosX near 1023 cannot wrap into an allowed value
        right_fits = ({1'b0, PosX} + SPRITE_W_W) < BOUND_W;
        walk_x = '0;
        if (left && !right && (XDist > MIN_DIST_W))
            walk_x = WALK_NEG;
        else if (right && !left && right_fits)
            walk_x = WALK_POS;
    end

    // Next-state: committed actions first, then a new hit, then fresh requests.
    always_comb begin
        state_d  = state_q;
        restart  = 1'b0;
        pend_d   = pend_q;
        jump_x_d = jump_x_q;
        unique case (state_q)
            S_HITSTUN: begin
                if (Hit)
                    restart = 1'b1;
                else if (cnt_q == HS_LAST)
                    state_d = S_IDLE;
            end
            S_JUMP: begin
                if (cnt_q == JUMP_LAST) begin
                    state_d = (pend_q || Hit) ? S_HITSTUN : S_IDLE;
                    pend_d  = 1'b0;
                end else if (Hit) begin
                    pend_d = 1'b1;
                end
            end
            S_ATTACK: begin
                if (Hit)
                    state_d = S_HITSTUN;
                else if (cnt_q == ATK_LAST)
                    state_d = S_IDLE;
            end
            default: begin
                if (Hit)
                    state_d = S_HITSTUN;
                else if (atk_rise)
                    state_d = S_ATTACK;
                else if (up) begin
                    state_d  = S_JUMP;
                    jump_x_d = walk_x;
                end else if (down)
                    state_d = S_CROUCH;
                else if (walk_x != '0)
                    state_d = S_WALK;
                else
                    state_d = S_IDLE;
            end
        endcase

        entry = restart || (state_d != state_q);
        if (entry)
            cnt_d = '0;
        else if (cnt_q == 5'h1F)
            cnt_d = cnt_q;
        else
            cnt_d = cnt_q + 5'd1;
    end

    always_comb begin
        x_d   = '0;
        y_d   = '0;
        aa_d  = 1'b0;
        air_d = 1'b0;
        unique case (state_d)
            S_WALK:    x_d = walk_x;
            S_JUMP: begin
                x_d   = jump_x_d;
                y_d   = {5'b0, cnt_d} - JUMP_V0_W;
                air_d = 1'b1;
            end
            S_ATTACK:  aa_d = (cnt_d >= ATK_ON_LO) && (cnt_d <= ATK_ON_HI);
            S_HITSTUN: x_d = KNOCK_W;
            default: ;
        endcase
    end

    always_ff @(posedge frame_clk or negedge Reset) begin
        if (!Reset) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            x_q        <= '0;
            y_q        <= '0;
            jump_x_q   <= '0;
            aa_q       <= 1'b0;
            air_q      <= 1'b0;
            pend_q     <= 1'b0;
            atk_prev_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            x_q        <= x_d;
            y_q        <= y_d;
            jump_x_q   <= jump_x_d;
            aa_q       <= aa_d;
            air_q      <= air_d;
            pend_q     <= pend_d;
            atk_prev_q <= atk;
        end
    end

    assign State        = state_q;
    assign X_Motion     = x_q;
    assign Y_Motion     = y_q;
    assign AttackActive = aa_q;
    assign Airborne     = air_q;

endmodule

// File: tb/tb_fighter_action_sched.sv
// Directed bench for fighter_action_sched: stimulus queues expected frames, a monitor checks them.
module tb_fighter_action_sched;

    localparam logic [2:0] ST_IDLE = 3'd0, ST_WALK = 3'd1, ST_CROUCH = 3'd2,
                           ST_JUMP = 3'd3, ST_ATTACK = 3'd4, ST_HITSTUN = 3'd5;
    localparam logic [7:0] K_LEFT = 8'h0D, K_RIGHT = 8'h0F, K_DOWN = 8'h0E,
                           K_UP = 8'h0C, K_ATK = 8'h10;
    localparam logic [4:0] M_ALL = 5'b11111, M_NOST = 5'b01111;

    logic       frame_clk = 1'b0;
    logic       Reset = 1'b1;
    logic [7:0] keycode_0 = '0, keycode_1 = '0, keycode_2 = '0, keycode_3 = '0;
    logic [9:0] XDist = 10'd200, PosX = 10'd400;
    logic       Hit = 1'b0;
    logic [9:0] X_Motion, Y_Motion;
    logic [2:0] State;
    logic       AttackActive, Airborne;

    fighter_action_sched dut (
        .frame_clk(frame_clk), .Reset(Reset),
        .keycode_0(keycode_0), .keycode_1(keycode_1),
        .keycode_2(keycode_2), .keycode_3(keycode_3),
        .XDist(XDist), .PosX(PosX), .Hit(Hit),
        .X_Motion(X_Motion), .Y_Motion(Y_Motion), .State(State),
        .AttackActive(AttackActive), .Airborne(Airborne)
    );

    always #5 frame_clk = ~frame_clk;

    typedef struct {
        int         cyc;
        bit         async_chk;
        string      nm;
        logic [2:0] st;
        logic [9:0] x;
        logic [9:0] y;
        logic       aa;
        logic       air;
        logic [4:0] m;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc = 0;

    always @(posedge frame_clk) cyc <= cyc + 1;

    task automatic check(input exp_t e);
        bit ok;
        ok = 1'b1;
        n_cmp++;
        if (e.m[4] && State        !== e.st)  ok = 1'b0;
        if (e.m[3] && X_Motion     !== e.x)   ok = 1'b0;
        if (e.m[2] && Y_Motion     !== e.y)   ok = 1'b0;
        if (e.m[1] && AttackActive !== e.aa)  ok = 1'b0;
        if (e.m[0] && Airborne     !== e.air) ok = 1'b0;
        if (!ok) begin
            n_bad++;
            $display("FAIL %s: got st=%0d x=%0d y=%0d aa=%0b air=%0b, want st=%0d x=%0d y=%0d aa=%0b air=%0b (mask %b)",
                     e.nm, State, $signed(X_Motion), $signed(Y_Motion), AttackActive, Airborne,
                     e.st, $signed(e.x), $signed(e.y), e.aa, e.air, e.m);
        end
    endtask

    // Monitor: wakes on every clock edge and on reset assertion
    initial begin
        exp_t e;
        forever begin
            @(posedge frame_clk or negedge Reset);
            #1;
            while (q.size() > 0 &&
                   ((q[0].async_chk && !Reset) || (!q[0].async_chk && q[0].cyc <= cyc))) begin
                e = q.pop_front();
                check(e);
            end
        end
    end

    function automatic exp_t mk(input string nm, input logic [2:0] st, input int x, input int y,
                                input logic aa, input logic air, input logic [4:0] m);
        exp_t e;
        e.cyc = cyc + 1;
        e.async_chk = 1'b0;
        e.nm = nm; e.st = st; e.x = 10'(x); e.y = 10'(y);
        e.aa = aa; e.air = air; e.m = m;
        return e;
    endfunction

    task automatic tick(input string nm, input logic [2:0] st, input int x, input int y,
                        input logic aa, input logic air, input logic [4:0] m);
        q.push_back(mk(nm, st, x, y, aa, air, m));
        @(posedge frame_clk);
        @(negedge frame_clk);
    endtask

    task automatic push_async(input string nm);
        exp_t e;
        e = mk(nm, ST_IDLE, 0, 0, 1'b0, 1'b0, M_ALL);
        e.async_chk = 1'b1;
        q.push_back(e);
    endtask

    task automatic keys(input logic [7:0] a, input logic [7:0] b);
        keycode_0 = a;
        keycode_1 = b;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        exp_t e;
        #2;
        push_async("reset_init");
        Reset = 1'b0;
        repeat (2) @(negedge frame_clk);
        Reset = 1'b1;

        tick("idle_after_reset", ST_IDLE, 0, 0, 0, 0, M_ALL);

        // walking right, including the 11-bit boundary
        keys(K_RIGHT, 0); PosX = 10'd400;
        tick("walk_r_400_a", ST_WALK, 2, 0, 0, 0, M_ALL);
        tick("walk_r_400_b", ST_WALK, 2, 0, 0, 0, M_ALL);
        PosX = 10'd510;
        tick("walk_r_blocked_510", ST_IDLE, 0, 0, 0, 0, M_NOST);
        PosX = 10'd509;
        tick("walk_r_edge_509", ST_WALK, 2, 0, 0, 0, M_ALL);

        // walking left against opponent distance
        keys(K_LEFT, 0); XDist = 10'd106;
        tick("walk_l_106", ST_WALK, -2, 0, 0, 0, M_ALL);
        XDist = 10'd105;
        tick("walk_l_blocked_105", ST_IDLE, 0, 0, 0, 0, M_NOST);

        XDist = 10'd200; PosX = 10'd400;
        keys(K_LEFT, K_RIGHT);
        tick("walk_both_keys", ST_IDLE, 0, 0, 0, 0, M_NOST);
        keys(K_DOWN, K_RIGHT);
        tick("crouch_over_walk", ST_CROUCH, 0, 0, 0, 0, M_ALL);
        keys(0, 0);
        tick("crouch_release", ST_IDLE, 0, 0, 0, 0, M_ALL);

        // full jump arc
        keys(K_UP, 0);
        tick("jump_f1", ST_JUMP, 0, -12, 0, 1, M_ALL);
        keys(0, 0);
        for (int i = 1; i < 25; i++)
            tick($sformatf("jump_f%0d", i + 1), ST_JUMP, 0, -12 + i, 0, 1, M_ALL);
        tick("jump_land", ST_IDLE, 0, 0, 0, 0, M_ALL);

        // held punch fires once
        keys(K_ATK, 0);
        for (int f = 1; f <= 20; f++)
            tick($sformatf("atk_hold_f%0d", f), (f <= 13) ? ST_ATTACK : ST_IDLE, 0, 0,
                 (f >= 5 && f <= 7), 0, M_ALL);
        keys(0, 0);
        tick("atk_release", ST_IDLE, 0, 0, 0, 0, M_ALL);

        // hit on attack frame 6 aborts it
        keys(K_ATK, 0);
        tick("atk2_f1", ST_ATTACK, 0, 0, 0, 0, M_ALL);
        keys(0, 0);
        for (int f = 2; f <= 6; f++)
            tick($sformatf("atk2_f%0d", f), ST_ATTACK, 0, 0, (f >= 5), 0, M_ALL);
        Hit = 1'b1;
        tick("atk2_hit_hs1", ST_HITSTUN, 3, 0, 0, 0, M_ALL);
        Hit = 1'b0;
        for (int f = 2; f <= 12; f++)
            tick($sformatf("atk2_hs%0d", f), ST_HITSTUN, 3, 0, 0, 0, M_ALL);
        tick("atk2_hs_done", ST_IDLE, 0, 0, 0, 0, M_ALL);

        // hit during hitstun restarts the count
        Hit = 1'b1;
        tick("hs_r_f1", ST_HITSTUN, 3, 0, 0, 0, M_ALL);
        Hit = 1'b0;
        for (int f = 2; f <= 5; f++)
            tick($sformatf("hs_r_f%0d", f), ST_HITSTUN, 3, 0, 0, 0, M_ALL);
        Hit = 1'b1;
        tick("hs_restart_f1", ST_HITSTUN, 3, 0, 0, 0, M_ALL);
        Hit = 1'b0;
        for (int f = 2; f <= 12; f++)
            tick($sformatf("hs_restart_f%0d", f), ST_HITSTUN, 3, 0, 0, 0, M_ALL);
        tick("hs_restart_done", ST_IDLE, 0, 0, 0, 0, M_ALL);

        // hit at jump frame 10 is deferred to landing
        keys(K_UP, 0);
        tick("jh_f1", ST_JUMP, 0, -12, 0, 1, M_ALL);
        keys(0, 0);
        for (int f = 2; f <= 10; f++)
            tick($sformatf("jh_f%0d", f), ST_JUMP, 0, -13 + f, 0, 1, M_ALL);
        Hit = 1'b1;
        tick("jh_f11_hit", ST_JUMP, 0, -2, 0, 1, M_ALL);
        Hit = 1'b0;
        for (int f = 12; f <= 25; f++)
            tick($sformatf("jh_f%0d", f), ST_JUMP, 0, -13 + f, 0, 1, M_ALL);
        tick("jh_land_hs1", ST_HITSTUN, 3, 0, 0, 0, M_ALL);
        for (int f = 2; f <= 12; f++)
            tick($sformatf("jh_hs%0d", f), ST_HITSTUN, 3, 0, 0, 0, M_ALL);
        tick("jh_done", ST_IDLE, 0, 0, 0, 0, M_ALL);

        // take-off walk latched, then reset mid-jump
        keys(K_UP, K_RIGHT); PosX = 10'd400;
        tick("jl_f1", ST_JUMP, 2, -12, 0, 1, M_ALL);
        keys(K_LEFT, 0);
        tick("jl_f2_latched", ST_JUMP, 2, -11, 0, 1, M_ALL);
        keys(0, 0);
        for (int f = 3; f <= 8; f++)
            tick($sformatf("jl_f%0d", f), ST_JUMP, 2, -13 + f, 0, 1, M_ALL);
        #2;
        push_async("reset_mid_jump");
        Reset = 1'b0;
        @(negedge frame_clk);
        keys(K_UP, 0);
        tick("reset_held", ST_IDLE, 0, 0, 0, 0, M_ALL);
        keys(K_ATK, 0);
        Reset = 1'b1;
        tick("post_reset_atk_edge", ST_ATTACK, 0, 0, 0, 0, M_ALL);
        keys(0, 0);

        for (int i = 0; i < 5 && q.size() > 0; i++) @(posedge frame_clk);
        #2;
        while (q.size() > 0) begin
            e = q.pop_front();
            n_cmp++;
            n_bad++;
            $display("FAIL %s: expectation never consumed, want st=%0d", e.nm, e.st);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
